// File: rtl/spi_cmd_decoder.sv
// SPI slave byte-level frame parser: READ/WRITE commands with big-endian address and burst auto-increment.
// Define SPI_CMD_STATUS_EN to add the RDSR (0x05) status opcode; the default build treats 0x05 as illegal.
module spi_cmd_decoder #(
   parameter logic [7:0]  CMD_READ  = 8'h03,
   parameter logic [7:0]  CMD_WRITE = 8'h02,
   parameter int unsigned ADDR_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cs_n,
   input  logic              rx_valid,
   input  logic [7:0]        rx_byte,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wr,
   output logic [7:0]        mem_wdata,
   output logic              mem_rd,
   input  logic [7:0]        mem_rdata,
   output logic              tx_load,
   output logic [7:0]        tx_byte,
   output logic              cmd_err
);

   localparam int unsigned NBYTES = ADDR_W / 8;
   localparam int unsigned CNT_W  = $clog2(NBYTES + 1);
`ifdef SPI_CMD_STATUS_EN
   localparam logic [7:0]  CMD_RDSR = 8'h05;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_WRITE,
      S_READ,
      S_ERR
   } state_t;

   state_t            state_q, state_d;
   logic              is_read_q, is_read_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              wr_q, wr_d;
   logic              rd_q, rd_d;
   logic              rd_pend_q, rd_pend_d;
   logic              tx_load_q, tx_load_d;
   logic [7:0]        tx_byte_q, tx_byte_d;
   logic              err_q, err_d;
`ifdef SPI_CMD_STATUS_EN
   logic              err_sticky_q, err_sticky_d;
   logic              wr_seen_q, wr_seen_d;
`endif

   always_comb begin
      state_d   = state_q;
      is_read_d = is_read_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wr_d      = 1'b0;
      rd_d      = 1'b0;
      rd_pend_d = rd_q;
      tx_load_d = 1'b0;
      tx_byte_d = tx_byte_q;
      err_d     = 1'b0;
`ifdef SPI_CMD_STATUS_EN
      err_sticky_d = err_sticky_q | err_q;
      wr_seen_d    = wr_seen_q | wr_q;
`endif

      // Post-write increment and read-data hand-off run regardless of cs_n so pending strobes finish.
      if (wr_q) begin
         addr_d = addr_q + ADDR_W'(1);
      end
      if (rd_pend_q) begin
         tx_load_d = 1'b1;
         tx_byte_d = mem_rdata;
      end

      if (cs_n) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: state_d = S_CMD;
            S_CMD: begin
               if (rx_valid) begin
                  if (rx_byte == CMD_READ || rx_byte == CMD_WRITE) begin
                     is_read_d = (rx_byte == CMD_READ);
                     cnt_d     = '0;
                     state_d   = S_ADDR;
`ifdef SPI_CMD_STATUS_EN
                  end else if (rx_byte == CMD_RDSR) begin
                     tx_load_d    = 1'b1;
                     tx_byte_d    = {6'b0, err_sticky_q, wr_seen_q};
                     err_sticky_d = 1'b0;
                     wr_seen_d    = 1'b0;
                     state_d      = S_ERR;
`endif
                  end else begin
                     err_d   = 1'b1;
                     state_d = S_ERR;
                  end
               end
            end
            S_ADDR: begin
               if (rx_valid) begin
                  addr_d = (addr_q << 8) | ADDR_W'(rx_byte);
                  cnt_d  = cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(NBYTES - 1)) begin
                     state_d = is_read_q ? S_READ : S_WRITE;
                     rd_d    = is_read_q;
                  end
               end
            end
            S_WRITE: begin
               if (rx_valid) begin
                  wr_d    = 1'b1;
                  wdata_d = rx_byte;
               end
            end
            S_READ: begin
               if (rx_valid) begin
                  addr_d = addr_q + ADDR_W'(1);
                  rd_d   = 1'b1;
               end
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         is_read_q <= 1'b0;
         cnt_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wr_q      <= 1'b0;
         rd_q      <= 1'b0;
         rd_pend_q <= 1'b0;
         tx_load_q <= 1'b0;
         tx_byte_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         is_read_q <= is_read_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wr_q      <= wr_d;
         rd_q      <= rd_d;
         rd_pend_q <= rd_pend_d;
         tx_load_q <= tx_load_d;
         tx_byte_q <= tx_byte_d;
         err_q     <= err_d;
      end
   end

`ifdef SPI_CMD_STATUS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_sticky_q <= 1'b0;
         wr_seen_q    <= 1'b0;
      end else begin
         err_sticky_q <= err_sticky_d;
         wr_seen_q    <= wr_seen_d;
      end
   end
`endif

   assign mem_addr  = addr_q;
   assign mem_wr    = wr_q;
   assign mem_wdata = wdata_q;
   assign mem_rd    = rd_q;
   assign tx_load   = tx_load_q;
   assign tx_byte   = tx_byte_q;
   assign cmd_err   = err_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed self-checking bench for spi_cmd_decoder with a byte-wide synchronous memory model.
module tb_spi_cmd_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        cs_n;
   logic        rx_valid;
   logic [7:0]  rx_byte;
   logic [15:0] mem_addr;
   logic        mem_wr;
   logic [7:0]  mem_wdata;
   logic        mem_rd;
   logic [7:0]  mem_rdata = 8'h00;
   logic        tx_load;
   logic [7:0]  tx_byte;
   logic        cmd_err;

   int vectors     = 0;
   int miscompares = 0;
   int wr_pulses   = 0;
   int rd_pulses   = 0;
   int tx_pulses   = 0;
   int err_pulses  = 0;

   logic [7:0] mem [0:65535];

   spi_cmd_decoder #(
      .CMD_READ  (8'h03),
      .CMD_WRITE (8'h02),
      .ADDR_W    (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cs_n      (cs_n),
      .rx_valid  (rx_valid),
      .rx_byte   (rx_byte),
      .mem_addr  (mem_addr),
      .mem_wr    (mem_wr),
      .mem_wdata (mem_wdata),
      .mem_rd    (mem_rd),
      .mem_rdata (mem_rdata),
      .tx_load   (tx_load),
      .tx_byte   (tx_byte),
      .cmd_err   (cmd_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rd) mem_rdata <= mem[mem_addr];
      if (mem_wr) mem[mem_addr] <= mem_wdata;
   end

   always @(posedge clk) begin
      if (mem_wr)  wr_pulses  <= wr_pulses + 1;
      if (mem_rd)  rd_pulses  <= rd_pulses + 1;
      if (tx_load) tx_pulses  <= tx_pulses + 1;
      if (cmd_err) err_pulses <= err_pulses + 1;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_byte  = b;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic frame_start;
      @(negedge clk);
      cs_n = 1'b0;
      tick(2);
   endtask

   task automatic frame_end;
      @(negedge clk);
      cs_n = 1'b1;
      tick(3);
   endtask

   task automatic test_reset;
      rst = 1'b1; cs_n = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00;
      tick(2);
      vectors++;
      if ({mem_addr, mem_wr, mem_wdata, mem_rd, tx_load, tx_byte, cmd_err} !== 36'h0) begin
         miscompares++;
         $display("FAIL reset_state: got addr=%h wr=%b wdata=%h rd=%b txl=%b txb=%h err=%b, expected all 0",
                  mem_addr, mem_wr, mem_wdata, mem_rd, tx_load, tx_byte, cmd_err);
      end
      rst = 1'b0;
      frame_start;
      send_byte(8'h02);
      send_byte(8'h12);
      vectors++;
      if (mem_addr !== 16'h0012) begin
         miscompares++;
         $display("FAIL partial_addr_before_reset: got %h expected 0012", mem_addr);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      vectors++;
      if ({mem_addr, mem_wr, mem_wdata, mem_rd, tx_load, tx_byte, cmd_err} !== 36'h0) begin
         miscompares++;
         $display("FAIL reset_mid_frame: got addr=%h wr=%b wdata=%h rd=%b txl=%b txb=%h err=%b, expected all 0",
                  mem_addr, mem_wr, mem_wdata, mem_rd, tx_load, tx_byte, cmd_err);
      end
      tick(1);
      rst = 1'b0;
      tick(1);
      send_byte(8'h02);
      send_byte(8'h56);
      send_byte(8'h78);
      send_byte(8'h9A);
      vectors++;
      if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, 16'h5678, 8'h9A}) begin
         miscompares++;
         $display("FAIL after_reset_write: got wr=%b addr=%h data=%h expected wr=1 addr=5678 data=9a",
                  mem_wr, mem_addr, mem_wdata);
      end
      frame_end;
   endtask

   task automatic test_write;
      logic [7:0]  wd [2];
      logic [15:0] ea;
      int          wr0;
      wd[0] = 8'hAA; wd[1] = 8'hBB;
      wr0 = wr_pulses;
      frame_start;
      send_byte(8'h02);
      send_byte(8'h12);
      send_byte(8'h34);
      tick(1);
      vectors++;
      if (mem_wr !== 1'b0) begin
         miscompares++;
         $display("FAIL write_no_strobe_on_addr: got wr=%b expected 0", mem_wr);
      end
      for (int i = 0; i < 2; i++) begin
         ea = 16'h1234 + 16'(i);
         send_byte(wd[i]);
         vectors++;
         if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, ea, wd[i]}) begin
            miscompares++;
            $display("FAIL write_beat%0d: got wr=%b addr=%h data=%h expected wr=1 addr=%h data=%h",
                     i, mem_wr, mem_addr, mem_wdata, ea, wd[i]);
         end
         tick(1);
         vectors++;
         if ({mem_wr, mem_addr} !== {1'b0, ea + 16'h0001}) begin
            miscompares++;
            $display("FAIL write_post%0d: got wr=%b addr=%h expected wr=0 addr=%h",
                     i, mem_wr, mem_addr, ea + 16'h0001);
         end
      end
      frame_end;
      vectors++;
      if (wr_pulses - wr0 !== 2) begin
         miscompares++;
         $display("FAIL write_count: got %0d expected 2", wr_pulses - wr0);
      end
   endtask

   task automatic test_read;
      logic [7:0]  trig [3];
      logic [7:0]  ed   [3];
      logic [15:0] ea;
      int          rd0, tx0;
      mem[16'h0010] = 8'h5A; mem[16'h0011] = 8'hC3; mem[16'h0012] = 8'h77;
      trig[0] = 8'h10; trig[1] = 8'hFF; trig[2] = 8'hEE;
      ed[0] = 8'h5A; ed[1] = 8'hC3; ed[2] = 8'h77;
      rd0 = rd_pulses; tx0 = tx_pulses;
      frame_start;
      send_byte(8'h03);
      send_byte(8'h00);
      for (int i = 0; i < 3; i++) begin
         ea = 16'h0010 + 16'(i);
         send_byte(trig[i]);
         vectors++;
         if ({mem_rd, mem_addr} !== {1'b1, ea}) begin
            miscompares++;
            $display("FAIL read_strobe%0d: got rd=%b addr=%h expected rd=1 addr=%h", i, mem_rd, mem_addr, ea);
         end
         tick(1);
         vectors++;
         if ({mem_rd, tx_load} !== 2'b00) begin
            miscompares++;
            $display("FAIL read_gap%0d: got rd=%b txl=%b expected 0 0", i, mem_rd, tx_load);
         end
         tick(1);
         vectors++;
         if ({tx_load, tx_byte} !== {1'b1, ed[i]}) begin
            miscompares++;
            $display("FAIL read_tx%0d: got txl=%b txb=%h expected txl=1 txb=%h", i, tx_load, tx_byte, ed[i]);
         end
         tick(1);
         vectors++;
         if (tx_load !== 1'b0) begin
            miscompares++;
            $display("FAIL read_tx_pulse%0d: got txl=%b expected 0", i, tx_load);
         end
      end
      frame_end;
      vectors++;
      if ({rd_pulses - rd0, tx_pulses - tx0} !== {32'd3, 32'd3}) begin
         miscompares++;
         $display("FAIL read_count: got rd=%0d tx=%0d expected 3 3", rd_pulses - rd0, tx_pulses - tx0);
      end
   endtask

   task automatic test_wrap;
      logic [7:0]  wd [2];
      logic [15:0] ea [2];
      wd[0] = 8'h01; wd[1] = 8'h02;
      ea[0] = 16'hFFFF; ea[1] = 16'h0000;
      frame_start;
      send_byte(8'h02);
      send_byte(8'hFF);
      send_byte(8'hFF);
      for (int i = 0; i < 2; i++) begin
         send_byte(wd[i]);
         vectors++;
         if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, ea[i], wd[i]}) begin
            miscompares++;
            $display("FAIL wrap_beat%0d: got wr=%b addr=%h data=%h expected wr=1 addr=%h data=%h",
                     i, mem_wr, mem_addr, mem_wdata, ea[i], wd[i]);
         end
      end
      frame_end;
      vectors++;
      if ({mem[16'hFFFF], mem[16'h0000]} !== 16'h0102) begin
         miscompares++;
         $display("FAIL wrap_memory: got ffff=%h 0000=%h expected 01 02", mem[16'hFFFF], mem[16'h0000]);
      end
   endtask

   task automatic test_illegal;
      int wr0, rd0, err0;
      wr0 = wr_pulses; rd0 = rd_pulses; err0 = err_pulses;
      frame_start;
      send_byte(8'h7E);
      vectors++;
      if (cmd_err !== 1'b1) begin
         miscompares++;
         $display("FAIL illegal_err_pulse: got %b expected 1", cmd_err);
      end
      tick(1);
      vectors++;
      if (cmd_err !== 1'b0) begin
         miscompares++;
         $display("FAIL illegal_err_width: got %b expected 0", cmd_err);
      end
      send_byte(8'h02);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h11);
      frame_end;
      vectors++;
      if ({wr_pulses - wr0, rd_pulses - rd0, err_pulses - err0} !== {32'd0, 32'd0, 32'd1}) begin
         miscompares++;
         $display("FAIL illegal_ignored: got wr=%0d rd=%0d err=%0d expected 0 0 1",
                  wr_pulses - wr0, rd_pulses - rd0, err_pulses - err0);
      end
      frame_start;
      send_byte(8'h02);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h11);
      vectors++;
      if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, 16'h0000, 8'h11}) begin
         miscompares++;
         $display("FAIL illegal_recover: got wr=%b addr=%h data=%h expected wr=1 addr=0000 data=11",
                  mem_wr, mem_addr, mem_wdata);
      end
      frame_end;
   endtask

   task automatic test_cs_abort;
      int wr0, rd0, tx0, err0;
      wr0 = wr_pulses; rd0 = rd_pulses; tx0 = tx_pulses; err0 = err_pulses;
      frame_start;
      send_byte(8'h03);
      send_byte(8'h00);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_byte  = 8'h20;
      cs_n     = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      tick(4);
      send_byte(8'h03);
      tick(2);
      frame_start;
      send_byte(8'h02);
      frame_end;
      frame_start;
      send_byte(8'h02);
      send_byte(8'hAB);
      frame_end;
      vectors++;
      if ({wr_pulses - wr0, rd_pulses - rd0, tx_pulses - tx0, err_pulses - err0} !== 128'h0) begin
         miscompares++;
         $display("FAIL abort_no_strobes: got wr=%0d rd=%0d tx=%0d err=%0d expected 0 0 0 0",
                  wr_pulses - wr0, rd_pulses - rd0, tx_pulses - tx0, err_pulses - err0);
      end
      frame_start;
      send_byte(8'h02);
      send_byte(8'hAB);
      send_byte(8'hCD);
      send_byte(8'h44);
      vectors++;
      if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, 16'hABCD, 8'h44}) begin
         miscompares++;
         $display("FAIL abort_recover: got wr=%b addr=%h data=%h expected wr=1 addr=abcd data=44",
                  mem_wr, mem_addr, mem_wdata);
      end
      frame_end;
   endtask

`ifdef SPI_CMD_STATUS_EN
   task automatic test_status;
      logic [7:0] pre [4];
      logic [7:0] es  [4];
      pre[0] = 8'h00; pre[1] = 8'h7E; pre[2] = 8'h02; pre[3] = 8'h00;
      es[0]  = 8'h00; es[1]  = 8'h02; es[2]  = 8'h01; es[3]  = 8'h00;
      @(negedge clk);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (pre[i] == 8'h7E) begin
            frame_start; send_byte(8'h7E); frame_end;
         end else if (pre[i] == 8'h02) begin
            frame_start; send_byte(8'h02); send_byte(8'h00); send_byte(8'h20); send_byte(8'h55); frame_end;
         end
         frame_start;
         send_byte(8'h05);
         vectors++;
         if ({tx_load, tx_byte, cmd_err} !== {1'b1, es[i], 1'b0}) begin
            miscompares++;
            $display("FAIL status%0d: got txl=%b txb=%h err=%b expected txl=1 txb=%h err=0",
                     i, tx_load, tx_byte, cmd_err, es[i]);
         end
         send_byte(8'h02);
         frame_end;
      end
   endtask
`else
   task automatic test_status;
      frame_start;
      send_byte(8'h05);
      vectors++;
      if ({cmd_err, tx_load} !== 2'b10) begin
         miscompares++;
         $display("FAIL rdsr_illegal: got err=%b txl=%b expected err=1 txl=0", cmd_err, tx_load);
      end
      frame_end;
   endtask
`endif

   initial begin
      test_reset;
      test_write;
      test_read;
      test_wrap;
      test_illegal;
      test_cs_abort;
      test_status;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
